// File: rtl/alu_pkg.sv
// Shared ALU definitions: op codes, legality check, response FSM states.
package alu_pkg;

  localparam int DefaultDataWidth = 32;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_SLL   = 4'd2,
    ALU_SLT   = 4'd3,
    ALU_SLTU  = 4'd4,
    ALU_XOR   = 4'd5,
    ALU_SRL   = 4'd6,
    ALU_SRA   = 4'd7,
    ALU_OR    = 4'd8,
    ALU_AND   = 4'd9,
    ALU_PASSB = 4'd15
  } alu_op_e;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } rsp_state_e;

  // Codes 10..14 have no ALU meaning.
  function automatic logic alu_op_legal(input logic [3:0] code);
    return !(code inside {[4'd10:4'd14]});
  endfunction

endpackage

// File: rtl/alu.sv
// Single-cycle RV32I-style ALU. Shift amounts use the full operand_b;
// illegal codes produce zero.
module alu
  import alu_pkg::*;
#(
  parameter int DataWidth = DefaultDataWidth
) (
  input  logic [DataWidth-1:0] operand_a,
  input  logic [DataWidth-1:0] operand_b,
  input  logic [3:0]           alu_control,
  output logic [DataWidth-1:0] result
);

  // Combinational operation select.
  always_comb begin
    result = '0;
    case (alu_control)
      ALU_ADD:   result = operand_a + operand_b;
      ALU_SUB:   result = operand_a - operand_b;
      ALU_SLL:   result = operand_a << operand_b;
      ALU_SLT:   result = {{(DataWidth-1){1'b0}}, ($signed(operand_a) < $signed(operand_b))};
      ALU_SLTU:  result = {{(DataWidth-1){1'b0}}, (operand_a < operand_b)};
      ALU_XOR:   result = operand_a ^ operand_b;
      ALU_SRL:   result = operand_a >> operand_b;
      ALU_SRA:   result = $signed(operand_a) >>> operand_b;
      ALU_OR:    result = operand_a | operand_b;
      ALU_AND:   result = operand_a & operand_b;
      ALU_PASSB: result = operand_b;
      default:   result = '0;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between NumReq requesters, with a
// single registered, id-tagged response channel.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int DataWidth = DefaultDataWidth,
  parameter int NumReq    = 2,
  parameter int IdWidth   = $clog2(NumReq)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NumReq-1:0]                req_valid,
  output logic [NumReq-1:0]                req_ready,
  input  logic [NumReq-1:0][DataWidth-1:0] req_operand_a,
  input  logic [NumReq-1:0][DataWidth-1:0] req_operand_b,
  input  logic [NumReq-1:0][3:0]           req_alu_control,
  output logic                             rsp_valid,
  input  logic                             rsp_ready,
  output logic [IdWidth-1:0]               rsp_id,
  output logic [DataWidth-1:0]             rsp_result,
  output logic                             rsp_illegal
);

  rsp_state_e           state_reg, state_next;
  logic [IdWidth-1:0]   prio_reg, prio_next;
  logic                 grant_valid;
  logic [IdWidth-1:0]   grant_idx;
  logic                 can_accept;
  logic                 load;
  logic [DataWidth-1:0] alu_a, alu_b, alu_result;
  logic [3:0]           alu_ctl;

  // Priority search starting at prio, wrapping modulo NumReq.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    for (int k = 0; k < NumReq; k++) begin
      if (!grant_valid && req_valid[(int'(prio_reg) + k) % NumReq]) begin
        grant_valid = 1'b1;
        grant_idx   = IdWidth'((int'(prio_reg) + k) % NumReq);
      end
    end
  end

  // Grant is only honoured when the response slot frees up this cycle;
  // reset also masks it so no requester sees a handshake while held.
  assign load = grant_valid && can_accept && !rst;

  for (genvar gi = 0; gi < NumReq; gi++) begin : g_ready
    assign req_ready[gi] = load && (grant_idx == IdWidth'(gi));
  end

  assign alu_a   = req_operand_a[grant_idx];
  assign alu_b   = req_operand_b[grant_idx];
  assign alu_ctl = req_alu_control[grant_idx];

  alu #(
    .DataWidth (DataWidth)
  ) u_alu (
    .operand_a   (alu_a),
    .operand_b   (alu_b),
    .alu_control (alu_ctl),
    .result      (alu_result)
  );

  // Next-state and accept logic for the response slot.
  always_comb begin
    state_next = state_reg;
    can_accept = 1'b0;
    case (state_reg)
      EMPTY: begin
        can_accept = 1'b1;
        if (grant_valid) state_next = FULL;
      end
      FULL: begin
        can_accept = rsp_ready;
        if (rsp_ready && !grant_valid) state_next = EMPTY;
      end
      default: state_next = EMPTY;
    endcase
  end

  // Round-robin pointer moves past each accepted requester.
  always_comb begin
    prio_next = prio_reg;
    if (load) begin
      prio_next = (grant_idx == IdWidth'(NumReq - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

  // State and pointer registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= EMPTY;
      prio_reg  <= '0;
    end else begin
      state_reg <= state_next;
      prio_reg  <= prio_next;
    end
  end

  // Response payload register; holds its value while EMPTY or stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_result  <= '0;
      rsp_id      <= '0;
      rsp_illegal <= 1'b0;
    end else if (load) begin
      rsp_result  <= alu_result;
      rsp_id      <= grant_idx;
      rsp_illegal <= !alu_op_legal(alu_ctl);
    end
  end

  assign rsp_valid = (state_reg == FULL);

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with NumReq=2, DataWidth=32.
module tb_alu_arbiter;
  import alu_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic [1:0]        req_valid;
  logic [1:0]        req_ready;
  logic [1:0][31:0]  req_operand_a;
  logic [1:0][31:0]  req_operand_b;
  logic [1:0][3:0]   req_alu_control;
  logic              rsp_valid;
  logic              rsp_ready;
  logic              rsp_id;
  logic [31:0]       rsp_result;
  logic              rsp_illegal;

  int tests  = 0;
  int failed = 0;

  alu_arbiter #(
    .DataWidth (32),
    .NumReq    (2)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_operand_a   (req_operand_a),
    .req_operand_b   (req_operand_b),
    .req_alu_control (req_alu_control),
    .rsp_valid       (rsp_valid),
    .rsp_ready       (rsp_ready),
    .rsp_id          (rsp_id),
    .rsp_result      (rsp_result),
    .rsp_illegal     (rsp_illegal)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b, input logic [3:0] c);
    req_operand_a[i]   = a;
    req_operand_b[i]   = b;
    req_alu_control[i] = c;
  endtask

  // Single request from requester 0; checks handshake and registered result.
  task automatic op0(input string tag, input logic [31:0] a, input logic [31:0] b,
                     input logic [3:0] c, input logic [31:0] exp);
    @(negedge clk);
    set_req(0, a, b, c);
    req_valid = 2'b01;
    #1 check({tag, "_ready"}, req_ready, 2'b01);
    @(posedge clk);
    #1;
    check({tag, "_result"}, rsp_result, exp);
    check({tag, "_id"}, rsp_id, 0);
    check({tag, "_illegal"}, rsp_illegal, 0);
    $display("[TB] op %s a=0x%08h b=0x%08h -> 0x%08h", tag, a, b, rsp_result);
  endtask

  initial begin
    rst             = 1'b1;
    req_valid       = '0;
    req_operand_a   = '0;
    req_operand_b   = '0;
    req_alu_control = '0;
    rsp_ready       = 1'b1;

    // Reset state; a valid request under reset must not see ready.
    repeat (2) @(negedge clk);
    set_req(0, 32'd5, 32'd7, ALU_ADD);
    req_valid = 2'b01;
    #1;
    check("rst_valid", rsp_valid, 0);
    check("rst_result", rsp_result, 0);
    check("rst_id", rsp_id, 0);
    check("rst_illegal", rsp_illegal, 0);
    check("rst_ready", req_ready, 2'b00);
    check("rst_prio", dut.prio_reg, 0);
    $display("[TB] reset state checked");

    // Single request: ADD 5+7
    @(negedge clk);
    rst = 1'b0;
    #1 check("t1_ready", req_ready, 2'b01);
    @(posedge clk);
    #1;
    check("t1_valid", rsp_valid, 1);
    check("t1_result", rsp_result, 32'd12);
    check("t1_id", rsp_id, 0);
    check("t1_illegal", rsp_illegal, 0);
    $display("[TB] single ADD 5+7 -> %0d id %0d", rsp_result, rsp_id);
    @(negedge clk);
    req_valid = 2'b00;
    #1 check("t1_idle_ready", req_ready, 2'b00);
    @(posedge clk);
    #1;
    check("t1_drained", rsp_valid, 0);
    check("t1_hold_result", rsp_result, 32'd12);

    // Illegal code from requester 1
    @(negedge clk);
    set_req(1, 32'h0000DEAD, 32'h0000BEEF, 4'd12);
    req_valid = 2'b10;
    #1 check("ill_ready", req_ready, 2'b10);
    @(posedge clk);
    #1;
    check("ill_valid", rsp_valid, 1);
    check("ill_result", rsp_result, 0);
    check("ill_flag", rsp_illegal, 1);
    check("ill_id", rsp_id, 1);
    check("ill_prio", dut.prio_reg, 0);
    $display("[TB] illegal code 12 -> result 0x%08h illegal %0d", rsp_result, rsp_illegal);

    // Round-robin with both requesters held valid
    @(negedge clk);
    set_req(0, 32'd10, 32'd3, ALU_SUB);
    set_req(1, 32'h80000000, 32'd4, ALU_SRA);
    req_valid = 2'b11;
    #1 check("rr0_ready", req_ready, 2'b01);
    @(posedge clk);
    #1;
    check("rr0_result", rsp_result, 32'd7);
    check("rr0_id", rsp_id, 0);
    check("rr0_illegal", rsp_illegal, 0);
    $display("[TB] rr grant 0 -> 0x%08h", rsp_result);
    @(negedge clk);
    #1 check("rr1_ready", req_ready, 2'b10);
    @(posedge clk);
    #1;
    check("rr1_result", rsp_result, 32'hF8000000);
    check("rr1_id", rsp_id, 1);
    $display("[TB] rr grant 1 -> 0x%08h", rsp_result);
    @(negedge clk);
    #1 check("rr2_ready", req_ready, 2'b01);
    @(posedge clk);
    #1;
    check("rr2_result", rsp_result, 32'd7);
    check("rr2_id", rsp_id, 0);
    check("rr2_prio", dut.prio_reg, 1);
    $display("[TB] rr grant 0 -> 0x%08h", rsp_result);

    // Backpressure for three cycles
    @(negedge clk);
    rsp_ready = 1'b0;
    #1 check("bp_ready_first", req_ready, 2'b00);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      check("bp_valid", rsp_valid, 1);
      check("bp_result", rsp_result, 32'd7);
      check("bp_id", rsp_id, 0);
      check("bp_prio", dut.prio_reg, 1);
      @(negedge clk);
      #1 check("bp_ready", req_ready, 2'b00);
      $display("[TB] backpressure cycle %0d held result 0x%08h", c, rsp_result);
    end
    rsp_ready = 1'b1;
    #1 check("bp_release_ready", req_ready, 2'b10);
    @(posedge clk);
    #1;
    check("bp_nobubble_valid", rsp_valid, 1);
    check("bp_next_result", rsp_result, 32'hF8000000);
    check("bp_next_id", rsp_id, 1);
    check("bp_next_prio", dut.prio_reg, 0);
    $display("[TB] drain+accept same cycle -> 0x%08h id %0d", rsp_result, rsp_id);

    // Reset while FULL with requester 1 next in line
    @(negedge clk);
    req_valid = 2'b01;
    #1 check("rf_pre_ready", req_ready, 2'b01);
    @(posedge clk);
    #1;
    check("rf_pre_valid", rsp_valid, 1);
    check("rf_pre_prio", dut.prio_reg, 1);
    @(negedge clk);
    req_valid = 2'b11;
    #1 rst = 1'b1;
    #1;
    check("rf_valid", rsp_valid, 0);
    check("rf_result", rsp_result, 0);
    check("rf_ready", req_ready, 2'b00);
    check("rf_prio", dut.prio_reg, 0);
    rst = 1'b0;
    #1 check("rf_after_ready", req_ready, 2'b01);
    @(posedge clk);
    #1;
    check("rf_after_result", rsp_result, 32'd7);
    check("rf_after_id", rsp_id, 0);
    $display("[TB] reset while full, first grant id %0d", rsp_id);

    // Edge ops and remaining codes
    op0("sltu", 32'd1, 32'hFFFFFFFF, ALU_SLTU, 32'd1);
    op0("slt", 32'd1, 32'hFFFFFFFF, ALU_SLT, 32'd0);
    op0("passb", 32'h0000ABCD, 32'h12345000, ALU_PASSB, 32'h12345000);
    op0("sll", 32'd1, 32'd31, ALU_SLL, 32'h80000000);
    op0("srl", 32'h80000000, 32'd4, ALU_SRL, 32'h08000000);
    op0("xor", 32'h0000F0F0, 32'h0000FF00, ALU_XOR, 32'h00000FF0);
    op0("or", 32'h0000F0F0, 32'h0000FF00, ALU_OR, 32'h0000FFF0);
    op0("and", 32'h0000F0F0, 32'h0000FF00, ALU_AND, 32'h0000F000);
    op0("sub_wrap", 32'd0, 32'd1, ALU_SUB, 32'hFFFFFFFF);
    op0("add_wrap", 32'hFFFFFFFF, 32'd1, ALU_ADD, 32'd0);

    // Idle drain
    @(negedge clk);
    req_valid = 2'b00;
    @(posedge clk);
    #1 check("end_empty", rsp_valid, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
